// File: rtl/prio_arbiter.sv
// prio_arbiter: registered N-way arbiter with fixed or round-robin priority.
// A grant is held until the consumer acks or the winning request is withdrawn.
module prio_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3,
  parameter int RR    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             ack,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_GRANT = 1'b1;
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N - 1);

  logic             state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [N-1:0]     prioMask;
  logic [N-1:0]     maskedReq;
  logic [IDX_W-1:0] winnerIdx;
  logic             releaseGrant;
  logic [IDX_W-1:0] ptrAfterRelease;

  function automatic logic [IDX_W-1:0] highestIdx(input logic [N-1:0] vec);
    logic [IDX_W-1:0] result;
    result = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) result = IDX_W'(i);
    end
    return result;
  endfunction

  // Round-robin: indices at or below ptr outrank those above it, so the
  // highest masked request wins; with none masked, the search wraps to N-1.
  always_comb begin
    prioMask = '0;
    for (int i = 0; i < N; i++) begin
      prioMask[i] = (IDX_W'(i) <= ptr_q);
    end
    maskedReq = req & prioMask;
    if ((RR != 0) && (maskedReq != '0)) winnerIdx = highestIdx(maskedReq);
    else                                winnerIdx = highestIdx(req);
  end

  assign releaseGrant    = ack || !req[idx_q];
  assign ptrAfterRelease = (idx_q == '0) ? PTR_INIT : idx_q - 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      STATE_IDLE: begin
        if (req != '0) begin
          state_d          = STATE_GRANT;
          gnt_d            = '0;
          gnt_d[winnerIdx] = 1'b1;
          idx_d            = winnerIdx;
          valid_d          = 1'b1;
        end
      end
      STATE_GRANT: begin
        if (releaseGrant) begin
          state_d = STATE_IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          ptr_d   = ptrAfterRelease;
        end
      end
      default: begin
        state_d = STATE_IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= PTR_INIT;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: a round-robin and a fixed-priority instance share
// stimulus and are checked each cycle against a search-order model.
module tb_prio_arbiter;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         ack = 1'b0;

  logic [N-1:0]     gntRr, gntFix;
  logic [IDX_W-1:0] idxRr, idxFix;
  logic             validRr, validFix;

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 1'b0;

  // Model state, entry 0 = fixed priority, entry 1 = round-robin.
  int mValid [2];
  int mIdx   [2];
  int mPtr   [2];

  prio_arbiter #(.N(N), .IDX_W(IDX_W), .RR(1)) dutRr (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .gnt(gntRr), .gnt_idx(idxRr), .gnt_valid(validRr)
  );

  prio_arbiter #(.N(N), .IDX_W(IDX_W), .RR(0)) dutFix (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .gnt(gntFix), .gnt_idx(idxFix), .gnt_valid(validFix)
  );

  always #5 clk = ~clk;

  function automatic int pickWinner(input bit rrMode, input int ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = rrMode ? (ptr - k + N) % N : N - 1 - k;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        mValid[m] = 0;
        mIdx[m]   = 0;
        mPtr[m]   = N - 1;
      end else if (mValid[m] == 0) begin
        if (req != '0) begin
          mIdx[m]   = pickWinner(m == 1, mPtr[m], req);
          mValid[m] = 1;
        end
      end else if (ack || !req[mIdx[m]]) begin
        mValid[m] = 0;
        mPtr[m]   = (mIdx[m] + N - 1) % N;
        mIdx[m]   = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [N-1:0] reqV, input logic ackV, input int cycles);
    req = reqV;
    ack = ackV;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("rr_valid", int'(validRr), mValid[1]);
      checkOutput("rr_idx",   int'(idxRr),   mIdx[1]);
      checkOutput("rr_gnt",   int'(gntRr),   (mValid[1] != 0) ? (1 << mIdx[1]) : 0);
      checkOutput("fix_valid", int'(validFix), mValid[0]);
      checkOutput("fix_idx",   int'(idxFix),   mIdx[0]);
      checkOutput("fix_gnt",   int'(gntFix),   (mValid[0] != 0) ? (1 << mIdx[0]) : 0);
    end
  end

  int sweepIdx [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  initial begin
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    checkEn = 1'b1;
    checkOutput("reset_valid", int'(validRr), 0);
    checkOutput("reset_gnt", int'(gntRr), 0);

    // Reset mid-grant clears outputs immediately.
    applyStimulus(8'h20, 1'b0, 1);
    checkOutput("t1_grant5_idx", int'(idxRr), 5);
    checkOutput("t1_grant5_gnt", int'(gntRr), 32'h20);
    rst_n = 1'b0;
    #1;
    checkOutput("t1_async_gnt", int'(gntRr), 0);
    checkOutput("t1_async_idx", int'(idxRr), 0);
    checkOutput("t1_async_valid", int'(validRr), 0);
    #1;
    rst_n = 1'b1;

    // Round-robin sweep with ack held high; fixed instance always picks 7.
    req = 8'hFF;
    ack = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk);
      #2;
      checkOutput("t3_sweep_valid", int'(validRr), (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) begin
        checkOutput("t3_sweep_idx", int'(idxRr), sweepIdx[k / 2]);
        checkOutput("t3_fixed_idx", int'(idxFix), 7);
      end
    end
    applyStimulus(8'h00, 1'b0, 2);
    checkOutput("t3_idle_valid", int'(validRr), 0);

    // Fixed priority with ack pulsed per grant.
    applyStimulus(8'h4E, 1'b0, 1);
    checkOutput("t2_fix_gnt", int'(gntFix), 32'h40);
    checkOutput("t2_fix_idx", int'(idxFix), 6);
    applyStimulus(8'h4E, 1'b1, 1);
    checkOutput("t2_released", int'(validFix), 0);
    applyStimulus(8'h4E, 1'b0, 1);
    checkOutput("t2_fix_idx2", int'(idxFix), 6);
    checkOutput("t2_rr_idx", int'(idxRr), 3);
    applyStimulus(8'h4E, 1'b1, 1);
    applyStimulus(8'h00, 1'b0, 3);
    checkOutput("t2_noreq_valid", int'(validFix), 0);

    // Round-robin wrap after idx 2 is released.
    applyStimulus(8'h04, 1'b0, 1);
    checkOutput("t4_grant2", int'(idxRr), 2);
    applyStimulus(8'h04, 1'b1, 1);
    applyStimulus(8'h84, 1'b0, 1);
    checkOutput("t4_wrap7", int'(idxRr), 7);
    applyStimulus(8'h84, 1'b1, 1);
    applyStimulus(8'h84, 1'b0, 1);
    checkOutput("t4_then2", int'(idxRr), 2);
    checkOutput("t4_fix7", int'(idxFix), 7);
    applyStimulus(8'h84, 1'b1, 1);

    // Withdrawal of the winning request releases the grant.
    applyStimulus(8'h08, 1'b0, 1);
    checkOutput("t5_grant3", int'(idxRr), 3);
    applyStimulus(8'h00, 1'b0, 1);
    checkOutput("t5_withdraw_valid", int'(validRr), 0);
    applyStimulus(8'h18, 1'b0, 1);
    checkOutput("t5_search4", int'(idxRr), 4);
    applyStimulus(8'h18, 1'b1, 1);

    // No preemption by a higher request during a grant.
    applyStimulus(8'h02, 1'b0, 1);
    checkOutput("t6_grant1", int'(idxRr), 1);
    applyStimulus(8'h82, 1'b0, 3);
    checkOutput("t6_held1", int'(idxRr), 1);
    checkOutput("t6_fix_held1", int'(idxFix), 1);
    applyStimulus(8'h82, 1'b1, 1);
    checkOutput("t6_ack_clear", int'(validRr), 0);
    applyStimulus(8'h82, 1'b0, 1);
    checkOutput("t6_grant7", int'(idxRr), 7);

    // Simultaneous ack and request drop is a single release.
    applyStimulus(8'h00, 1'b1, 1);
    checkOutput("t7_dual_release", int'(validRr), 0);
    applyStimulus(8'h00, 1'b0, 2);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
